// File: rtl/instr_fetch_buffer_pkg.sv
// Shared types for the instruction fetch buffer: the fetch packet held in the
// queue and the default queue depth.
package instr_fetch_buffer_pkg;

   localparam int DEFAULT_QUEUE_DEPTH = 4;

   typedef struct packed {
      logic [63:0] instr;   // slot1 in [63:32], slot0 in [31:0]
      logic [63:0] pc;      // slot1 pc in [63:32], slot0 pc in [31:0]
      logic [1:0]  valid;
      logic [1:0]  pred;    // predicted-taken, already masked by valid
   } fetch_pkt_t;

   function automatic logic [5:0] taken_count(input logic [1:0] pred);
      return {5'b0, pred[0]} + {5'b0, pred[1]};
   endfunction

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Memory request/response, redirect and decoder-side signals of the fetch buffer.
// master = the fetch buffer itself, slave = memory/decoder/branch unit side.
interface instr_fetch_buffer_if;

   logic        OUT_memReq;
   logic [31:0] OUT_memAddr;
   logic        IN_memReady;
   logic        IN_memValid;
   logic [63:0] IN_memData;
   logic [1:0]  IN_predTaken;
   logic [31:0] IN_predTarget;
   logic        IN_redirect;
   logic [31:0] IN_redirectPC;
   logic [5:0]  IN_redirectBranchID;
   logic        IN_stall;
   logic [63:0] OUT_instr;
   logic [1:0]  OUT_instrValid;
   logic [1:0]  OUT_branchPred;
   logic [11:0] OUT_branchID;
   logic [63:0] OUT_pc;

   modport master (
      output OUT_memReq, OUT_memAddr, OUT_instr, OUT_instrValid,
             OUT_branchPred, OUT_branchID, OUT_pc,
      input  IN_memReady, IN_memValid, IN_memData, IN_predTaken, IN_predTarget,
             IN_redirect, IN_redirectPC, IN_redirectBranchID, IN_stall
   );

   modport slave (
      input  OUT_memReq, OUT_memAddr, OUT_instr, OUT_instrValid,
             OUT_branchPred, OUT_branchID, OUT_pc,
      output IN_memReady, IN_memValid, IN_memData, IN_predTaken, IN_predTarget,
             IN_redirect, IN_redirectPC, IN_redirectBranchID, IN_stall
   );

endinterface

// File: rtl/instr_fetch_buffer_fetch_queue.sv
// Circular FIFO of fetch packets with push, pop, flush and a combinational head.
// A packet pushed in one cycle is visible at the head in the next.
module fetch_queue
   import instr_fetch_buffer_pkg::*;
#(
   parameter int DEPTH = DEFAULT_QUEUE_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  fetch_pkt_t               push_data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output fetch_pkt_t               head_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_pkt_t        mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push;
   logic              do_pop;

   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Depth is a power of two, so the count MSB alone means "full".
   assert property (@(posedge clk) disable iff (rst) !(do_push && count_q[PTR_W]));

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues 8-byte aligned fetches under a credit limit,
// turns in-order responses into two-slot packets and feeds them to the decoder.
module instr_fetch_buffer
   import instr_fetch_buffer_pkg::*;
#(
   parameter int          QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input logic                  clk,
   input logic                  rst,
   instr_fetch_buffer_if.master bus
);

   localparam int PTR_W  = $clog2(QUEUE_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int CRED_W = CNT_W + 1;

   logic [31:0]      fpc_q, fpc_d;
   logic [CNT_W-1:0] outst_q, outst_d;
   logic [CNT_W-1:0] discard_q, discard_d;
   logic [5:0]       bid_q, bid_d;
   logic [CNT_W-1:0] q_count;
   logic             q_empty;

   // In-flight request tracker: {addr[31:3], start slot} per outstanding fetch.
   logic [29:0]      inflight_q [QUEUE_DEPTH];
   logic [PTR_W-1:0] if_wr_q, if_rd_q;

   logic             mem_req;
   logic             accept;
   logic             resp;
   logic             keep;
   logic             pred_redir;
   logic             pop;
   logic [29:0]      rsp_ent;
   logic [31:0]      rsp_base;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_pred;
   fetch_pkt_t       rsp_pkt;
   fetch_pkt_t       head;
   logic [11:0]      bid_out;

   assign mem_req = !rst &&
                    ((CRED_W'(q_count) + CRED_W'(outst_q)) < CRED_W'(QUEUE_DEPTH));
   assign accept  = mem_req && bus.IN_memReady;
   assign resp    = bus.IN_memValid && (outst_q != '0);
   assign keep    = resp && !bus.IN_redirect && (discard_q == '0);
   assign pop     = !q_empty && !bus.IN_stall && !bus.IN_redirect;

   always_comb begin
      rsp_ent   = inflight_q[if_rd_q];
      rsp_base  = {rsp_ent[29:1], 3'b000};
      rsp_valid = rsp_ent[0] ? 2'b10 : 2'b11;
      rsp_pred  = bus.IN_predTaken & rsp_valid;
      // A taken slot0 ends the packet: slot1 lies on the wrong path.
      if (rsp_pred[0]) begin
         rsp_valid[1] = 1'b0;
         rsp_pred[1]  = 1'b0;
      end
      rsp_pkt.instr = bus.IN_memData;
      rsp_pkt.pc    = {rsp_base + 32'd4, rsp_base};
      rsp_pkt.valid = rsp_valid;
      rsp_pkt.pred  = rsp_pred;
      pred_redir    = keep && (rsp_pred != 2'b00);
   end

   always_comb begin
      fpc_d = fpc_q;
      if (accept)          fpc_d = {fpc_q[31:3], 3'b000} + 32'd8;
      if (pred_redir)      fpc_d = bus.IN_predTarget;
      if (bus.IN_redirect) fpc_d = bus.IN_redirectPC;

      outst_d = outst_q + CNT_W'(accept) - CNT_W'(resp);

      // Every fetch still in flight after a redirect is on the wrong path.
      discard_d = discard_q;
      if (resp && !bus.IN_redirect && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
      if (pred_redir || bus.IN_redirect)                 discard_d = outst_d;

      bid_d = bid_q;
      if (bus.IN_redirect) bid_d = bus.IN_redirectBranchID;
      else if (pop)        bid_d = bid_q + taken_count(head.pred);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc_q     <= RESET_PC;
         outst_q   <= '0;
         discard_q <= '0;
         bid_q     <= '0;
         if_wr_q   <= '0;
         if_rd_q   <= '0;
      end else begin
         fpc_q     <= fpc_d;
         outst_q   <= outst_d;
         discard_q <= discard_d;
         bid_q     <= bid_d;
         if (accept) if_wr_q <= if_wr_q + PTR_W'(1);
         if (resp)   if_rd_q <= if_rd_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) inflight_q[if_wr_q] <= {fpc_q[31:3], fpc_q[2]};
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_fetch_queue (
      .clk         (clk),
      .rst         (rst),
      .push_i      (keep),
      .push_data_i (rsp_pkt),
      .pop_i       (pop),
      .flush_i     (bus.IN_redirect),
      .head_o      (head),
      .empty_o     (q_empty),
      .count_o     (q_count)
   );

   // Each slot's branchID skips the IDs taken by earlier predicted-taken slots.
   for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      localparam logic [1:0] BEFORE_MASK = 2'((1 << gi) - 1);
      assign bid_out[gi*6 +: 6] = bid_q + taken_count(head.pred & BEFORE_MASK);
   end

   assign bus.OUT_memReq     = mem_req;
   assign bus.OUT_memAddr    = {fpc_q[31:3], 3'b000};
   assign bus.OUT_instrValid = q_empty ? 2'b00 : head.valid;
   assign bus.OUT_instr      = head.instr;
   assign bus.OUT_pc         = head.pc;
   assign bus.OUT_branchPred = head.pred;
   assign bus.OUT_branchID   = bid_out;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Scoreboard bench for instr_fetch_buffer: a small in-order memory and
// fetch model predict every request and every packet popped by the decoder.
module tb_instr_fetch_buffer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_fetch_buffer_if bus ();

   instr_fetch_buffer #(
      .QUEUE_DEPTH (4),
      .RESET_PC    (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] pc;
      bit          doomed;
   } req_t;

   typedef struct {
      logic [63:0] instr;
      logic [31:0] pc0;
      logic [31:0] pc1;
      logic [1:0]  valid;
      logic [1:0]  pred;
   } exp_t;

   req_t        pend_q[$];
   exp_t        exp_q[$];
   logic [31:0] m_fpc;
   logic [5:0]  m_bid;
   int          checks   = 0;
   int          failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic [63:0] mem_data(input logic [31:0] a);
      if (a == 32'h0) return 64'h00A00093_00100013;
      return {a ^ 32'h5A5A_0004, ~a};
   endfunction

   function automatic int pick(input int mode);
      if (mode == 2) return int'($urandom_range(0, 1));
      return mode;
   endfunction

   // One clock: drive inputs, check outputs at the falling edge, advance the model.
   task automatic cyc(input int ready, input int rsp, input int pred, input logic [31:0] tgt,
                      input int stall, input int redir, input logic [31:0] rpc, input int rbid);
      bit          do_rsp;
      bit          exp_req;
      bit          acc;
      bit          pop;
      req_t        r;
      exp_t        e;
      logic [31:0] base;
      logic [1:0]  v;
      logic [1:0]  p;
      do_rsp = (rsp != 0) && (pend_q.size() > 0);
      bus.IN_memReady         = (ready != 0);
      bus.IN_memValid         = do_rsp;
      bus.IN_memData          = 64'h0;
      if (do_rsp) bus.IN_memData = mem_data({pend_q[0].pc[31:3], 3'b000});
      bus.IN_predTaken        = 2'(pred);
      bus.IN_predTarget       = tgt;
      bus.IN_stall            = (stall != 0);
      bus.IN_redirect         = (redir != 0);
      bus.IN_redirectPC       = rpc;
      bus.IN_redirectBranchID = 6'(rbid);
      @(negedge clk);

      exp_req = (exp_q.size() + pend_q.size()) < 4;
      chk("memReq", 64'(bus.OUT_memReq), 64'(exp_req));
      if (exp_req) chk("memAddr", 64'(bus.OUT_memAddr), 64'({m_fpc[31:3], 3'b000}));
      if (exp_q.size() > 0) chk("instrValid", 64'(bus.OUT_instrValid), 64'(exp_q[0].valid));
      else                  chk("instrValid", 64'(bus.OUT_instrValid), 64'(2'b00));

      pop = (exp_q.size() > 0) && (stall == 0) && (redir == 0);
      if (pop) begin
         e = exp_q.pop_front();
         chk("branchPred", 64'(bus.OUT_branchPred), 64'(e.pred));
         if (e.valid[0]) begin
            chk("pc0", 64'(bus.OUT_pc[31:0]), 64'(e.pc0));
            chk("instr0", 64'(bus.OUT_instr[31:0]), 64'(e.instr[31:0]));
            chk("bid0", 64'(bus.OUT_branchID[5:0]), 64'(m_bid));
         end
         if (e.valid[1]) begin
            chk("pc1", 64'(bus.OUT_pc[63:32]), 64'(e.pc1));
            chk("instr1", 64'(bus.OUT_instr[63:32]), 64'(e.instr[63:32]));
            chk("bid1", 64'(bus.OUT_branchID[11:6]), 64'(m_bid + 6'(e.pred[0])));
         end
         $display("pop pc0=%h pc1=%h valid=%b pred=%b bid=%0d", e.pc0, e.pc1, e.valid, e.pred, m_bid);
         m_bid = m_bid + 6'(e.pred[0]) + 6'(e.pred[1]);
      end

      acc = exp_req && (ready != 0);
      if (acc) begin
         r.pc     = m_fpc;
         r.doomed = 1'b0;
         pend_q.push_back(r);
         m_fpc = {m_fpc[31:3], 3'b000} + 32'd8;
      end

      if (do_rsp) begin
         r = pend_q.pop_front();
         if ((redir == 0) && !r.doomed) begin
            base = {r.pc[31:3], 3'b000};
            v    = r.pc[2] ? 2'b10 : 2'b11;
            p    = 2'(pred) & v;
            if (p[0]) begin
               v = 2'b01;
               p = 2'b01;
            end
            e.instr = mem_data(base);
            e.pc0   = base;
            e.pc1   = base + 32'd4;
            e.valid = v;
            e.pred  = p;
            exp_q.push_back(e);
            if (p != 2'b00) begin
               m_fpc = tgt;
               foreach (pend_q[i]) pend_q[i].doomed = 1'b1;
            end
         end
      end

      if (redir != 0) begin
         foreach (pend_q[i]) pend_q[i].doomed = 1'b1;
         exp_q.delete();
         m_fpc = rpc;
         m_bid = 6'(rbid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n, input int rdy_mode, input int rsp_mode, input int stl_mode);
      for (int i = 0; i < n; i++) cyc(pick(rdy_mode), pick(rsp_mode), 0, 32'h0, pick(stl_mode), 0, 32'h0, 0);
   endtask

   task automatic drain();
      for (int i = 0; (i < 40) && ((exp_q.size() + pend_q.size()) > 0); i++)
         cyc(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
      chk("drain_empty", 64'(bus.OUT_instrValid), 64'(2'b00));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.IN_memReady = 1'b0;
      bus.IN_memValid = 1'b0;
      bus.IN_redirect = 1'b0;
      bus.IN_stall    = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_memReq", 64'(bus.OUT_memReq), 64'(1'b0));
         chk("rst_instrValid", 64'(bus.OUT_instrValid), 64'(2'b00));
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      pend_q.delete();
      exp_q.delete();
      m_fpc = 32'h0;
      m_bid = 6'd0;
   endtask

   initial begin
      bus.IN_memReady         = 1'b0;
      bus.IN_memValid         = 1'b0;
      bus.IN_memData          = 64'h0;
      bus.IN_predTaken        = 2'b00;
      bus.IN_predTarget       = 32'h0;
      bus.IN_redirect         = 1'b0;
      bus.IN_redirectPC       = 32'h0;
      bus.IN_redirectBranchID = 6'd0;
      bus.IN_stall            = 1'b0;
      do_reset();

      // Credit limit: four fetches from 0x0 upward, then the request drops.
      run(6, 1, 0, 0);
      // First response carries the fixed pair at 0x0; all four drain in order.
      drain();

      run(60, 2, 2, 2);
      drain();

      // Redirect with two fetches in flight: both responses are discarded.
      run(2, 1, 0, 0);
      cyc(0, 0, 0, 32'h0, 0, 1, 32'h0000_0104, 5);
      drain();
      cyc(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
      drain();

      // Predicted-taken slot0 with branchID counter at 63.
      cyc(0, 0, 0, 32'h0, 0, 1, 32'h0000_0300, 63);
      run(3, 1, 0, 0);
      cyc(0, 1, 1, 32'h0000_0200, 1, 0, 32'h0, 0);
      cyc(0, 1, 0, 32'h0, 1, 0, 32'h0, 0);
      cyc(0, 1, 0, 32'h0, 1, 0, 32'h0, 0);
      drain();
      cyc(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
      drain();

      // Redirect coinciding with an accepted request and a returning response.
      run(2, 1, 0, 0);
      cyc(1, 1, 0, 32'h0, 0, 1, 32'h0000_0040, 7);
      drain();
      run(1, 1, 0, 0);
      drain();

      // Decoder stalled: queue fills, request stops, then four packets drain.
      run(10, 1, 1, 1);
      drain();

      // Reset in the middle of traffic, then fetch restarts at the reset PC.
      run(4, 1, 1, 1);
      do_reset();
      run(3, 1, 0, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/instr_fetch_buffer.md
INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- QUEUE_DEPTH, 4, packet entries (power of 2, >=2)
- RESET_PC, 32'h0000_0000, fetch PC after reset
REQ-002 SHALL have ports, one per line: name direction width meaning.
- clk input 1 sole clock; everything samples on its rising edge
- rst input 1 synchronous, active-high reset
- OUT_memReq output 1 fetch request valid
- OUT_memAddr output 32 request address, 8-byte aligned
- IN_memReady input 1 memory accepts request this cycle
- IN_memValid input 1 response valid; responses return in request order
- IN_memData input 64 two instructions: slot0=[31:0] at addr, slot1=[63:32] at addr+4
- IN_predTaken input 2 per-slot predicted-taken, valid with response
- IN_predTarget input 32 target of the first predicted-taken slot
- IN_redirect input 1 flush and restart fetch
- IN_redirectPC input 32 restart PC, 4-byte aligned
- IN_redirectBranchID input 6 branchID counter value after redirect
- IN_stall input 1 decoder cannot accept the head packet
- OUT_instr output 64 to decoder IN_instr
- OUT_instrValid output 2 to decoder IN_instrValid
- OUT_branchPred output 2 to decoder IN_branchPred
- OUT_branchID output 12 to decoder IN_branchID, 6 bits per slot
- OUT_pc output 64 to decoder IN_pc, 32 bits per slot

Function
REQ-003 SHALL keep fetch PC fpc; OUT_memAddr = {fpc[31:3],3'b0}; OUT_memReq=1 iff (queue count + outstanding) < QUEUE_DEPTH and not rst.
REQ-004 SHALL, on request accepted (OUT_memReq & IN_memReady), set fpc to {fpc[31:3],3'b0}+8 and increment outstanding.
REQ-005 SHALL record per outstanding request the start slot (fpc[2]); a start slot of 1 makes slot0 invalid in that packet.
REQ-006 SHALL, on non-discarded response, write one entry: data, pc per slot (base, base+4), valid mask, predTaken masked by valid; decrement outstanding.
REQ-007 SHALL, if the first valid slot with predTaken is slot0, invalidate slot1, and set fpc to IN_predTarget, discarding all responses to requests issued after that request.
REQ-008 SHALL present the queue head combinationally: OUT_instrValid = head mask when queue non-empty, else 2'b0; other outputs don't-care when invalid.
REQ-009 SHALL pop the head on (non-empty & !IN_stall); entry written in cycle N is visible at head in N+1; simultaneous push and pop SHALL leave count unchanged.
REQ-010 SHALL hold a 6-bit branchID counter; slot k branchID = counter + number of predicted-taken valid slots before k; on pop counter advances by popped predicted-taken count, wrapping 63->0.
REQ-011 SHALL, on IN_redirect: empty the queue, set fpc=IN_redirectPC, counter=IN_redirectBranchID, discard count=outstanding (including any request accepted that cycle); same-cycle response SHALL be dropped; no pop that cycle.
REQ-012 SHALL drop responses while discard count > 0, decrementing discard count and outstanding.
REQ-013 SHALL never write a full queue; credit rule REQ-003 guarantees this; assertion required.

Reset
REQ-014 SHALL on rst: fpc=RESET_PC, queue empty, outstanding=0, discard=0, counter=0, OUT_memReq=0, OUT_instrValid=2'b0.
REQ-015 SHALL let rst override IN_redirect and in-flight responses; responses arriving after reset are dropped only if memory issued them (memory is reset concurrently).

Structure
REQ-016 SHALL place the fetch packet struct (instr, pc, valid mask, pred mask) and QUEUE_DEPTH default in the shared package.
REQ-017 SHALL use one sub-module, fetch_queue, a synchronous circular FIFO with push/pop/flush and head read.

Verification
REQ-018 Reset then IN_memReady=1: first OUT_memAddr=0x0, next 0x8; OUT_memReq drops after 4 outstanding with no responses.
REQ-019 Response data 0x00A00093_00100013 for addr 0x0: next cycle OUT_instrValid=2'b11, OUT_pc={32'h4,32'h0}, pop when IN_stall=0.
REQ-020 Redirect to 0x104 with 2 outstanding: next two responses dropped; first kept packet has OUT_instrValid=2'b10, pc slot1=0x104.
REQ-021 IN_predTaken=2'b01, target 0x200, branchID counter 63: slot1 invalid, slot0 branchID 63, next popped counter 0, next request 0x200.
REQ-022 IN_stall=1 for 10 cycles: queue fills to 4, OUT_memReq=0, no data lost; release drains 4 packets in order.
